// File: rtl/reg_file_sb.sv
// Register file with a pending-write scoreboard: destinations are reserved at issue
// and released at writeback; reads bypass same-cycle writeback data.

module reg_file_sb_rd_port #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = 5
) (
    input  logic [AW-1:0]               rd_addr,
    input  logic [NREGS-1:0][XLEN-1:0]  regs,
    input  logic [NREGS-1:0]            pending,
    input  logic                        wb_valid,
    input  logic [AW-1:0]               wb_rd,
    input  logic [XLEN-1:0]             wb_data,
    output logic [XLEN-1:0]             rd_data,
    output logic                        rd_busy
);
    logic addr_zero;
    logic wb_match;

    always_comb begin
        addr_zero = (rd_addr == '0);
        wb_match  = wb_valid && (wb_rd == rd_addr) && !addr_zero;
        rd_data   = regs[rd_addr];
        if (addr_zero) rd_data = '0;
        if (wb_match)  rd_data = wb_data;
        // A writeback landing this cycle already satisfies the dependency.
        rd_busy   = pending[rd_addr] && !wb_match && !addr_zero;
    end
endmodule

module reg_file_sb #(
    parameter  int XLEN  = 32,
    parameter  int NREGS = 32,
    parameter  int NRD   = 2,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                 Clock,
    input  logic                 nReset,
    input  logic [NRD*AW-1:0]    rdAddr,
    output logic [NRD*XLEN-1:0]  rdData,
    output logic [NRD-1:0]       rdBusy,
    input  logic                 issueValid,
    input  logic [AW-1:0]        issueRd,
    output logic                 issueReady,
    input  logic                 wbValid,
    input  logic [AW-1:0]        wbRd,
    input  logic [XLEN-1:0]      wbData,
    output logic [AW:0]          pendCount,
    output logic                 wbErr
);
    if (XLEN < 8 || NREGS < 4 || (1 << AW) != NREGS || NRD < 1 || NRD > 4) begin : g_param_chk
        $error("reg_file_sb: illegal parameter combination");
    end

    logic [NREGS-1:0][XLEN-1:0] regs_q, regs_d;
    logic [NREGS-1:0]           pending_q, pending_d;
    logic [AW:0]                pend_count_q, pend_count_d;
    logic                       wb_err_q, wb_err_d;

    logic wb_hit;
    logic wb_clr;
    logic issue_set;

    always_comb begin
        wb_hit     = wbValid && (wbRd != '0);
        wb_clr     = wb_hit && pending_q[wbRd];
        issueReady = (issueRd == '0) || !pending_q[issueRd] || (wbValid && (wbRd == issueRd));
        issue_set  = issueValid && issueReady && (issueRd != '0);

        regs_d    = regs_q;
        pending_d = pending_q;
        if (wb_hit) begin
            regs_d[wbRd]    = wbData;
            pending_d[wbRd] = 1'b0;
        end
        // Set after clear so a same-cycle re-issue keeps the register reserved.
        if (issue_set) pending_d[issueRd] = 1'b1;
        regs_d[0]    = '0;
        pending_d[0] = 1'b0;

        pend_count_d = pend_count_q;
        case ({issue_set, wb_clr})
            2'b10:   pend_count_d = pend_count_q + 1'b1;
            2'b01:   pend_count_d = pend_count_q - 1'b1;
            default: pend_count_d = pend_count_q;
        endcase

        wb_err_d = wb_hit && !pending_q[wbRd];
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            regs_q       <= '0;
            pending_q    <= '0;
            pend_count_q <= '0;
            wb_err_q     <= 1'b0;
        end else begin
            regs_q       <= regs_d;
            pending_q    <= pending_d;
            pend_count_q <= pend_count_d;
            wb_err_q     <= wb_err_d;
        end
    end

    assign pendCount = pend_count_q;
    assign wbErr     = wb_err_q;

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        reg_file_sb_rd_port #(
            .XLEN  (XLEN),
            .NREGS (NREGS),
            .AW    (AW)
        ) u_port (
            .rd_addr  (rdAddr[i*AW +: AW]),
            .regs     (regs_q),
            .pending  (pending_q),
            .wb_valid (wbValid),
            .wb_rd    (wbRd),
            .wb_data  (wbData),
            .rd_data  (rdData[i*XLEN +: XLEN]),
            .rd_busy  (rdBusy[i])
        );
    end
endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 Parameter XLEN, 32, data width in bits; SHALL be >= 8.
REQ-002 Parameter NREGS, 32, register count; SHALL be a power of two >= 4; AW = log2(NREGS).
REQ-003 Parameter NRD, 2, number of read ports; SHALL be 1..4.
REQ-004 Clock  input  1  rising-edge clock.
REQ-005 nReset  input  1  reset, asynchronous, active-low.
REQ-006 rdAddr  input  NRD*AW  read addresses; port i in bits [i*AW +: AW].
REQ-007 rdData  output  NRD*XLEN  read data; port i in bits [i*XLEN +: XLEN].
REQ-008 rdBusy  output  NRD  port i register has a write pending.
REQ-009 issueValid  input  1  request to reserve issueRd as pending destination.
REQ-010 issueRd  input  AW  destination register to reserve.
REQ-011 issueReady  output  1  reservation can be accepted this cycle.
REQ-012 wbValid  input  1  writeback strobe.
REQ-013 wbRd  input  AW  writeback register address.
REQ-014 wbData  input  XLEN  writeback data.
REQ-015 pendCount  output  AW+1  number of registers currently pending.
REQ-016 wbErr  output  1  registered one-cycle pulse: writeback to non-pending register.

Function
REQ-017 Register 0 SHALL always read 0, SHALL never be written, and SHALL never be pending.
REQ-018 Writeback: on rising Clock with wbValid=1 and wbRd!=0, reg[wbRd] <= wbData, and pending[wbRd] SHALL be cleared.
REQ-019 Reads SHALL be combinational; rdData[i] = wbData when wbValid=1, wbRd=rdAddr[i] and rdAddr[i]!=0 (same-cycle bypass); otherwise reg[rdAddr[i]].
REQ-020 rdBusy[i] = pending[rdAddr[i]] AND NOT (wbValid AND wbRd=rdAddr[i]); rdBusy[i]=0 when rdAddr[i]=0.
REQ-021 issueReady = NOT pending[issueRd] OR (wbValid AND wbRd=issueRd); issueReady=1 when issueRd=0.
REQ-022 Issue accepted = issueValid AND issueReady; when accepted with issueRd!=0, pending[issueRd] SHALL be 1 after the edge.
REQ-023 Issue accepted and writeback to the same nonzero register in one cycle: data SHALL be written and pending SHALL end at 1 (set wins).
REQ-024 issueValid with issueReady=0 SHALL have no effect; the requester holds its request.
REQ-025 pendCount SHALL equal the population count of pending[] after every edge: +1 on accepted nonzero issue, -1 on writeback clearing a pending bit, unchanged when both occur.
REQ-026 Writeback with wbRd!=0 to a non-pending register SHALL still write data and SHALL raise wbErr for exactly the following cycle; wbErr SHALL never be raised for wbRd=0.
REQ-027 Writeback with wbRd=0 SHALL be ignored entirely (no write, no count change, no error).
REQ-028 All read ports SHALL be independent; identical addresses on several ports SHALL return identical data and busy.

Reset
REQ-029 nReset low SHALL asynchronously clear all registers, all pending bits, pendCount and wbErr to 0.
REQ-030 Reset asserted mid-operation SHALL discard all reservations; no pending state SHALL survive deassertion.
REQ-031 After reset release, issueReady=1 for every issueRd and rdBusy=0 on all ports.

Verification
REQ-032 Reset, then write 0xDEADBEEF to r5; read r5 on both ports next cycle -> rdData=0xDEADBEEF, rdBusy=0, pendCount=0, wbErr pulses 1 cycle.
REQ-033 Issue r7; next cycle issue r7 again -> issueReady=0, rdBusy=1 on r7, pendCount=1; then wbValid r7 data 0x12345678 same cycle as re-issue -> issueReady=1, rdData=0x12345678 (bypass), pendCount stays 1, pending[r7]=1.
REQ-034 wbValid r0 data 0xFFFFFFFF, issue r0 -> reading r0 returns 0, rdBusy=0, pendCount=0, wbErr=0.
REQ-035 Issue r1,r2,r3 on consecutive cycles, then writeback r2 and issue r4 in one cycle -> pendCount 1,2,3,3; wbErr=0.
REQ-036 Issue r9, assert nReset mid-pending for one cycle -> pendCount=0, r9 reads 0, rdBusy=0, issueReady=1.
REQ-037 NRD=4, XLEN=16, NREGS=8 build: all four ports read distinct registers with correct data, no cross-port aliasing.
